host_mem_loader: RTL and testbench

//  Host-side controller for the multicore top level's external memory port. Takes a 16-bit

---
 rtl/host_mem_loader.sv | 245 ++++++++++++++++++++++++
 tb/tb_host_mem_loader.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_mem_loader.sv
// Host-side loader for the multicore top level's external memory port.
// It consumes a 16-bit word stream: a header and the words for the IRAMs,
// a header and the words for the shared DRAM, then a header giving the
// number of DRAM words to read back after the cores have run.
//
// Handshakes: an input word transfers on a rising edge where
// in_valid & in_ready are both high. An output word transfers on a rising
// edge where out_valid & out_ready are both high. out_valid and out_data
// stay stable until that transfer happens.
module host_mem_loader #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 16,
    parameter int READ_LAT    = 2,
    parameter int RUN_TIMEOUT = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_go,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              cores_done,
    output logic              start,
    output logic              start_2,
    output logic              start_3,
    output logic              start_4,
    output logic [ADDR_W-1:0] addr_ext,
    output logic              iram_write_ext_1,
    output logic              iram_write_ext_2,
    output logic [DATA_W-1:0] Data_in_ins,
    output logic              dram_write_ext,
    output logic [DATA_W-1:0] Data_in_dram,
    output logic              read_en_ext,
    input  logic [DATA_W-1:0] dram_in_1,
    output logic              busy,
    output logic              error,
    output logic [3:0]        dbg_state
);

    typedef enum logic [3:0] {
        IDLE, HDR_I, LOAD_I, HDR_D, LOAD_D, HDR_R,
        GAP_PRE, RUN, GAP_POST, DUMP_RD, DUMP_OUT
    } state_t;

    localparam logic [9:0]  MAX_LEN  = 10'(1 << ADDR_W);
    localparam logic [31:0] RUN_LAST = 32'((RUN_TIMEOUT > 0) ? RUN_TIMEOUT - 1 : 0);
    localparam logic [7:0]  LAT_LAST = 8'(READ_LAT);

    state_t            state, next_state;
    logic [9:0]        count;
    logic              phase_b;      // second cycle of a two-cycle memory write
    logic [DATA_W-1:0] word_q;       // word held for the second write cycle
    logic [1:0]        mask_q;
    logic [9:0]        ilen_q, dlen_q, rlen_q;
    logic [31:0]       run_cnt;
    logic [7:0]        lat_cnt;
    logic              hdr_err, run_timeout;

    logic [9:0] hdr_len;
    logic       len_bad;
    assign hdr_len = in_data[9:0];
    assign len_bad = (hdr_len > MAX_LEN);

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // State register; asynchronous reset aborts any session at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state and all memory-port outputs, decoded from the current state.
    always_comb begin
        next_state       = state;
        in_ready         = 1'b0;
        start            = 1'b0;
        start_2          = 1'b0;
        start_3          = 1'b0;
        start_4          = 1'b0;
        addr_ext         = '0;
        iram_write_ext_1 = 1'b0;
        iram_write_ext_2 = 1'b0;
        Data_in_ins      = '0;
        dram_write_ext   = 1'b0;
        Data_in_dram     = '0;
        read_en_ext      = 1'b0;
        hdr_err          = 1'b0;
        run_timeout      = 1'b0;
        case (state)
            IDLE: if (cmd_go) next_state = HDR_I;
            HDR_I: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (len_bad || (in_data[15:14] == 2'b00 && hdr_len != 10'd0)) begin
                        hdr_err    = 1'b1;
                        next_state = IDLE;
                    end else if (hdr_len == 10'd0) next_state = HDR_D;
                    else                           next_state = LOAD_I;
                end
            end
            LOAD_I: begin
                start_2  = 1'b1;
                addr_ext = count[ADDR_W-1:0];
                if (!phase_b) begin
                    in_ready         = 1'b1;
                    Data_in_ins      = in_data;
                    iram_write_ext_1 = in_valid & mask_q[0];
                    iram_write_ext_2 = in_valid & mask_q[1];
                end else begin
                    Data_in_ins      = word_q;
                    iram_write_ext_1 = mask_q[0];
                    iram_write_ext_2 = mask_q[1];
                    if (count == ilen_q - 10'd1) next_state = HDR_D;
                end
            end
            HDR_D: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (len_bad) begin
                        hdr_err    = 1'b1;
                        next_state = IDLE;
                    end else if (hdr_len == 10'd0) next_state = HDR_R;
                    else                           next_state = LOAD_D;
                end
            end
            LOAD_D: begin
                start_3  = 1'b1;
                addr_ext = count[ADDR_W-1:0];
                if (!phase_b) begin
                    in_ready       = 1'b1;
                    Data_in_dram   = in_data;
                    dram_write_ext = in_valid;
                end else begin
                    Data_in_dram   = word_q;
                    dram_write_ext = 1'b1;
                    if (count == dlen_q - 10'd1) next_state = HDR_R;
                end
            end
            HDR_R: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (len_bad) begin
                        hdr_err    = 1'b1;
                        next_state = IDLE;
                    end else next_state = GAP_PRE;
                end
            end
            GAP_PRE: next_state = RUN;
            RUN: begin
                start = 1'b1;
                if (cores_done) begin
                    next_state = (rlen_q == 10'd0) ? IDLE : GAP_POST;
                end else if (RUN_TIMEOUT != 0 && run_cnt == RUN_LAST) begin
                    run_timeout = 1'b1;
                    next_state  = IDLE;
                end
            end
            GAP_POST: next_state = DUMP_RD;
            DUMP_RD: begin
                start_4     = 1'b1;
                read_en_ext = 1'b1;
                addr_ext    = count[ADDR_W-1:0];
                if (lat_cnt == LAT_LAST) next_state = DUMP_OUT;
            end
            DUMP_OUT: begin
                start_4  = 1'b1;
                addr_ext = count[ADDR_W-1:0];
                if (out_valid && out_ready)
                    next_state = (count == rlen_q - 10'd1) ? IDLE : DUMP_RD;
            end
            default: next_state = IDLE;
        endcase
    end

    // Counters, captured header fields, held write word, output register, error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            phase_b   <= 1'b0;
            word_q    <= '0;
            mask_q    <= '0;
            ilen_q    <= '0;
            dlen_q    <= '0;
            rlen_q    <= '0;
            run_cnt   <= '0;
            lat_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (hdr_err || run_timeout) error <= 1'b1;
            case (state)
                IDLE: if (cmd_go) begin
                    error <= 1'b0;
                    count <= '0;
                end
                HDR_I: if (in_valid) begin
                    mask_q <= in_data[15:14];
                    ilen_q <= hdr_len;
                    count  <= '0;
                end
                HDR_D: if (in_valid) begin
                    dlen_q <= hdr_len;
                    count  <= '0;
                end
                HDR_R: if (in_valid) begin
                    rlen_q <= hdr_len;
                    count  <= '0;
                end
                LOAD_I, LOAD_D: begin
                    if (!phase_b) begin
                        if (in_valid) begin
                            word_q  <= in_data;
                            phase_b <= 1'b1;
                        end
                    end else begin
                        phase_b <= 1'b0;
                        count   <= count + 10'd1;
                    end
                end
                GAP_PRE:  run_cnt <= '0;
                RUN:      run_cnt <= run_cnt + 32'd1;
                GAP_POST: lat_cnt <= '0;
                DUMP_RD: begin
                    lat_cnt <= lat_cnt + 8'd1;
                    if (lat_cnt == LAT_LAST) begin
                        out_data  <= dram_in_1;
                        out_valid <= 1'b1;
                    end
                end
                DUMP_OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    count     <= count + 10'd1;
                    lat_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_host_mem_loader.sv
// Bench for host_mem_loader: stream sessions, DRAM read-back model, scoreboards.
module tb_host_mem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_go = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        cores_done = 1'b1;
    logic        start, start_2, start_3, start_4;
    logic [8:0]  addr_ext;
    logic        iram_write_ext_1, iram_write_ext_2;
    logic [15:0] Data_in_ins;
    logic        dram_write_ext;
    logic [15:0] Data_in_dram;
    logic        read_en_ext;
    logic [15:0] dram_in_1;
    logic        busy, error;
    logic [3:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // write events: {we1, we2, dram_we, addr[8:0], data[15:0]}
    logic [27:0] exp_q[$];
    logic [15:0] out_q[$];

    logic [15:0] dram_mem [0:511];
    logic [15:0] rd_d0, rd_d1;
    logic        any_strobe = 1'b0;
    logic        saw_start4 = 1'b0;
    int          start_cycles = 0;
    logic        rdy_toggle = 1'b0;
    logic [3:0]  prev_strobes = '0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;

    always #5 clock = ~clock;

    host_mem_loader #(.RUN_TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .cmd_go(cmd_go),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cores_done(cores_done),
        .start(start), .start_2(start_2), .start_3(start_3), .start_4(start_4),
        .addr_ext(addr_ext),
        .iram_write_ext_1(iram_write_ext_1), .iram_write_ext_2(iram_write_ext_2),
        .Data_in_ins(Data_in_ins), .dram_write_ext(dram_write_ext),
        .Data_in_dram(Data_in_dram), .read_en_ext(read_en_ext),
        .dram_in_1(dram_in_1), .busy(busy), .error(error), .dbg_state(dbg_state)
    );

    // DRAM read port model: data valid READ_LAT=2 cycles after address presented.
    always @(posedge clock) begin
        rd_d0 <= (start_4 && read_en_ext) ? dram_mem[addr_ext] : 16'hDEAD;
        rd_d1 <= rd_d0;
    end
    assign dram_in_1 = rd_d1;

    // Backpressure pattern for the dump test.
    always @(posedge clock) begin
        if (rdy_toggle) begin
            #1 out_ready = ~out_ready;
        end
    end

    // Monitor: write scoreboard, dump scoreboard, strobe rules, stall stability.
    always @(negedge clock) begin
        logic [3:0]  strobes;
        logic [27:0] obs, exp;
        logic [15:0] oexp;
        if (!reset) begin
            strobes = {start, start_2, start_3, start_4};
            if (strobes != 4'b0) any_strobe = 1'b1;
            if (start_4) saw_start4 = 1'b1;
            if (start) start_cycles++;
            checks++;
            if ($countones(strobes) > 1) begin
                errors++;
                $display("FAIL strobe_excl: strobes=%b required at most one high", strobes);
            end
            checks++;
            if (prev_strobes != 4'b0 && strobes != 4'b0 && strobes != prev_strobes) begin
                errors++;
                $display("FAIL phase_gap: strobes %b -> %b required an all-low cycle between", prev_strobes, strobes);
            end
            checks++;
            if (((iram_write_ext_1 || iram_write_ext_2) && !start_2) || (dram_write_ext && !start_3)) begin
                errors++;
                $display("FAIL we_strobe: we1=%b we2=%b dwe=%b s2=%b s3=%b required enables only under strobe",
                         iram_write_ext_1, iram_write_ext_2, dram_write_ext, start_2, start_3);
            end
            if (iram_write_ext_1 || iram_write_ext_2 || dram_write_ext) begin
                obs = {iram_write_ext_1, iram_write_ext_2, dram_write_ext, addr_ext,
                       start_2 ? Data_in_ins : Data_in_dram};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got %h required no write", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL write_event: got %h required %h", obs, exp);
                    end
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_stable: valid=%b data=%h required valid=1 data=%h", out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_q.size() == 0) begin
                    errors++;
                    $display("FAIL dump_unexpected: got %h required no output", out_data);
                end else begin
                    oexp = out_q.pop_front();
                    if (out_data !== oexp) begin
                        errors++;
                        $display("FAIL dump_word: got %h required %h", out_data, oexp);
                    end
                end
            end
            prev_stall   = out_valid && !out_ready;
            prev_data    = out_data;
            prev_strobes = strobes;
        end else begin
            prev_strobes = '0;
            prev_stall   = 1'b0;
        end
    end

    function automatic logic [27:0] wr_ev(input logic [2:0] we, input int a, input logic [15:0] d);
        return {we, 9'(a), d};
    endfunction

    task automatic pulse_go();
        cmd_go = 1'b1;
        @(posedge clock); #1;
        cmd_go = 1'b0;
    endtask

    // Offer one word; returns with the transfer complete (posedge + 1).
    task automatic send_word(input logic [15:0] w, output logic ok);
        int n = 0;
        ok = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clock);
            if (in_ready === 1'b1) ok = 1'b1;
            @(posedge clock); #1;
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output logic ok);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({busy, error, in_ready, out_valid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: busy/err/in_ready/out_valid=%b required 0000", {busy, error, in_ready, out_valid});
        end
        checks++;
        if ({start, start_2, start_3, start_4, read_en_ext, dram_write_ext, iram_write_ext_1, iram_write_ext_2} !== 8'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 0", {start, start_2, start_3, start_4});
        end
        checks++;
        if (addr_ext !== 9'd0 || out_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h out=%h required 0/0", addr_ext, out_data);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_iram_load();
        logic ok, all_ok;
        logic [15:0] words [3];
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        all_ok = 1'b1;
        pulse_go();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL iram_busy: busy=%b required 1", busy);
        end
        send_word(16'hC003, ok); all_ok &= ok;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(wr_ev(3'b110, i, words[i]));
            exp_q.push_back(wr_ev(3'b110, i, words[i]));
            send_word(words[i], ok); all_ok &= ok;
        end
        send_word(16'h0000, ok); all_ok &= ok;
        send_word(16'h0000, ok); all_ok &= ok;
        wait_idle(50, ok); all_ok &= ok;
        checks++;
        if (!all_ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL iram_session: ok=%b pending=%0d required 1/0", all_ok, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_dram_load();
        logic ok, all_ok;
        all_ok = 1'b1;
        saw_start4 = 1'b0;
        pulse_go();
        send_word(16'h4000, ok); all_ok &= ok;
        send_word(16'h0002, ok); all_ok &= ok;
        exp_q.push_back(wr_ev(3'b001, 0, 16'hAAAA));
        exp_q.push_back(wr_ev(3'b001, 0, 16'hAAAA));
        send_word(16'hAAAA, ok); all_ok &= ok;
        exp_q.push_back(wr_ev(3'b001, 1, 16'hBBBB));
        exp_q.push_back(wr_ev(3'b001, 1, 16'hBBBB));
        send_word(16'hBBBB, ok); all_ok &= ok;
        send_word(16'h0000, ok); all_ok &= ok;
        wait_idle(50, ok); all_ok &= ok;
        checks++;
        if (!all_ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL dram_session: ok=%b pending=%0d required 1/0", all_ok, exp_q.size());
        end
        checks++;
        if (saw_start4 !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL dram_no_dump: start_4_seen=%b error=%b required 0/0", saw_start4, error);
        end
        exp_q.delete();
    endtask

    task automatic test_dump();
        logic ok, all_ok;
        all_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dram_mem[i] = 16'($urandom_range(0, 65535));
            out_q.push_back(dram_mem[i]);
        end
        pulse_go();
        send_word(16'h4000, ok); all_ok &= ok;
        send_word(16'h0000, ok); all_ok &= ok;
        out_ready  = 1'b0;
        rdy_toggle = 1'b1;
        send_word(16'h0003, ok); all_ok &= ok;
        wait_idle(200, ok); all_ok &= ok;
        rdy_toggle = 1'b0;
        #2 out_ready = 1'b1;
        checks++;
        if (!all_ok || out_q.size() != 0) begin
            errors++;
            $display("FAIL dump_session: ok=%b pending=%0d required 1/0", all_ok, out_q.size());
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump_valid_clear: out_valid=%b required 0", out_valid);
        end
        out_q.delete();
    endtask

    task automatic test_bad_header();
        logic ok;
        any_strobe = 1'b0;
        pulse_go();
        send_word(16'hC201, ok);
        checks++;
        if (!ok || error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_len: ok=%b error=%b busy=%b required 1/1/0", ok, error, busy);
        end
        repeat (3) @(posedge clock); #1;
        checks++;
        if (any_strobe !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("FAIL bad_len_quiet: strobe_seen=%b error=%b required 0/1", any_strobe, error);
        end
        pulse_go();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_on_go: error=%b required 0", error);
        end
        send_word(16'h0005, ok);
        checks++;
        if (!ok || error !== 1'b1 || busy !== 1'b0 || any_strobe !== 1'b0) begin
            errors++;
            $display("FAIL bad_mask: ok=%b error=%b busy=%b strobe=%b required 1/1/0/0", ok, error, busy, any_strobe);
        end
    endtask

    task automatic test_timeout();
        logic ok, all_ok;
        all_ok = 1'b1;
        cores_done   = 1'b0;
        start_cycles = 0;
        saw_start4   = 1'b0;
        pulse_go();
        send_word(16'h4000, ok); all_ok &= ok;
        send_word(16'h0000, ok); all_ok &= ok;
        send_word(16'h0002, ok); all_ok &= ok;
        wait_idle(100, ok); all_ok &= ok;
        @(negedge clock);
        checks++;
        if (!all_ok || start_cycles != 16) begin
            errors++;
            $display("FAIL run_timeout_len: ok=%b start_cycles=%0d required 1/16", all_ok, start_cycles);
        end
        checks++;
        if (error !== 1'b1 || saw_start4 !== 1'b0) begin
            errors++;
            $display("FAIL run_timeout_err: error=%b start_4_seen=%b required 1/0", error, saw_start4);
        end
        cores_done = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_midload();
        logic ok, all_ok;
        all_ok = 1'b1;
        pulse_go();
        send_word(16'h4000, ok); all_ok &= ok;
        send_word(16'h0003, ok); all_ok &= ok;
        exp_q.push_back(wr_ev(3'b001, 0, 16'h1234));
        exp_q.push_back(wr_ev(3'b001, 0, 16'h1234));
        send_word(16'h1234, ok); all_ok &= ok;
        @(negedge clock);
        @(posedge clock); #2;
        checks++;
        if (start_3 !== 1'b1 || addr_ext !== 9'd1) begin
            errors++;
            $display("FAIL midload_state: start_3=%b addr=%0d required 1/1", start_3, addr_ext);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, start_3, in_ready, dram_write_ext, error, out_valid} !== 6'b0 || addr_ext !== 9'd0) begin
            errors++;
            $display("FAIL async_reset: flags=%b addr=%0d required 0/0",
                     {busy, start_3, in_ready, dram_write_ext, error, out_valid}, addr_ext);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        pulse_go();
        send_word(16'h8001, ok); all_ok &= ok;
        exp_q.push_back(wr_ev(3'b010, 0, 16'h5A5A));
        exp_q.push_back(wr_ev(3'b010, 0, 16'h5A5A));
        send_word(16'h5A5A, ok); all_ok &= ok;
        send_word(16'h0000, ok); all_ok &= ok;
        send_word(16'h0000, ok); all_ok &= ok;
        wait_idle(50, ok); all_ok &= ok;
        checks++;
        if (!all_ok || exp_q.size() != 0 || error !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_session: ok=%b pending=%0d error=%b required 1/0/0", all_ok, exp_q.size(), error);
        end
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) dram_mem[i] = '0;
        test_reset();
        test_iram_load();
        test_dram_load();
        test_dump();
        test_bad_header();
        test_timeout();
        test_reset_midload();
        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
